rx_ctrl: RTL and testbench

Receive-side controller for the USRT rxshift byte shifter. Gates the shifter's enable, validates the stop bit, and buffers accepted bytes in a small FIFO drained through a valid/ready port. Latches baud configuration per session and flags framing, overrun and configuration errors. Sits between rxshift and the host/register interface.

---
 rtl/rx_ctrl_if.sv | 36 +++
 rtl/rx_ctrl.sv | 154 +++++++++++++++
 tb/tb_rx_ctrl.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_ctrl_if.sv
// Host and rxshift signal bundle for rx_ctrl; the controller connects through
// the slave modport, and the driving side (host/bench) uses master.
interface rx_ctrl_if #(
  parameter int AW = 2
);
  logic          i_Rx_En;
  logic [7:0]    i_Baud;
  logic          i_Rx_Serial;
  logic          o_Shift_Enable;
  logic [7:0]    o_Shift_Baud;
  logic [7:0]    i_Shift_Data;
  logic          i_Shift_Done;
  logic [7:0]    o_Rx_Data;
  logic          o_Rx_Valid;
  logic          i_Rx_Ready;
  logic [AW:0]   o_Count;
  logic          o_Busy;
  logic          o_Frame_Err;
  logic          o_Overrun;
  logic          o_Cfg_Err;
  logic          i_Clr_Err;

  modport slave (
    input  i_Rx_En, i_Baud, i_Rx_Serial, i_Shift_Data, i_Shift_Done,
           i_Rx_Ready, i_Clr_Err,
    output o_Shift_Enable, o_Shift_Baud, o_Rx_Data, o_Rx_Valid, o_Count,
           o_Busy, o_Frame_Err, o_Overrun, o_Cfg_Err
  );

  modport master (
    output i_Rx_En, i_Baud, i_Rx_Serial, i_Shift_Data, i_Shift_Done,
           i_Rx_Ready, i_Clr_Err,
    input  o_Shift_Enable, o_Shift_Baud, o_Rx_Data, o_Rx_Valid, o_Count,
           o_Busy, o_Frame_Err, o_Overrun, o_Cfg_Err
  );
endinterface

// File: rtl/rx_ctrl.sv
// USRT receive controller: arms rxshift after an idle line, checks the stop
// bit, and buffers accepted bytes in a DEPTH-entry FIFO with sticky errors.
module rx_ctrl #(
  parameter int DEPTH    = 4,
  parameter int AW       = 2,
  parameter int IDLE_CYC = 4
) (
  input logic        i_Pclk,
  input logic        i_Rst,
  rx_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_LISTEN, S_STOP} state_e;

  localparam int ICW = $clog2(IDLE_CYC + 1);
  localparam logic [ICW-1:0] ICNT_ONE  = ICW'(1);
  localparam logic [ICW-1:0] ICNT_LAST = ICW'(IDLE_CYC - 1);
  localparam logic [AW:0]    CNT_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0]    CNT_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0]  PTR_ONE   = AW'(1);

  state_e          state_q, state_d;
  logic [ICW-1:0]  idle_cnt_q, idle_cnt_d;
  logic [7:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      baud_q, baud_d;
  logic [7:0]      hold_q, hold_d;
  logic            fe_q, fe_d, ov_q, ov_d, ce_q, ce_d;

  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     cnt_q, cnt_d;

  logic            good_stop, fe_set, ce_set, ov_set;
  logic            push, pop, full;

  assign full = (cnt_q == CNT_FULL);
  assign pop  = (cnt_q != '0) & bus.i_Rx_Ready;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts the byte.
  assign push   = good_stop & (~full | pop);
  assign ov_set = good_stop & full & ~pop;

  always_comb begin
    state_d    = state_q;
    idle_cnt_d = idle_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    baud_d     = baud_q;
    hold_d     = hold_q;
    good_stop  = 1'b0;
    fe_set     = 1'b0;
    ce_set     = 1'b0;
    if (!bus.i_Rx_En) begin
      state_d    = S_IDLE;
      idle_cnt_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          idle_cnt_d = '0;
          if (bus.i_Baud >= 8'd2) begin
            baud_d  = bus.i_Baud;
            state_d = S_ARM;
          end else begin
            ce_set = 1'b1;
          end
        end
        S_ARM: begin
          if (bus.i_Rx_Serial) begin
            if (idle_cnt_q == ICNT_LAST) begin
              idle_cnt_d = '0;
              state_d    = S_LISTEN;
            end else begin
              idle_cnt_d = idle_cnt_q + ICNT_ONE;
            end
          end else begin
            idle_cnt_d = '0;
          end
        end
        S_LISTEN: begin
          if (bus.i_Shift_Done) begin
            hold_d    = bus.i_Shift_Data;
            bit_cnt_d = '0;
            state_d   = S_STOP;
          end
        end
        S_STOP: begin
          // Sample mid-way through the stop bit.
          if (bit_cnt_q == (baud_q >> 1)) begin
            if (bus.i_Rx_Serial) good_stop = 1'b1;
            else                 fe_set    = 1'b1;
            idle_cnt_d = '0;
            state_d    = S_ARM;
          end else begin
            bit_cnt_d = bit_cnt_q + 8'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
    fe_d = (fe_q & ~bus.i_Clr_Err) | fe_set;
    ov_d = (ov_q & ~bus.i_Clr_Err) | ov_set;
    ce_d = (ce_q & ~bus.i_Clr_Err) | ce_set;
  end

  always_ff @(posedge i_Pclk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q    <= S_IDLE;
      idle_cnt_q <= '0;
      bit_cnt_q  <= '0;
      baud_q     <= '0;
      hold_q     <= '0;
      fe_q       <= 1'b0;
      ov_q       <= 1'b0;
      ce_q       <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      idle_cnt_q <= idle_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      baud_q     <= baud_d;
      hold_q     <= hold_d;
      fe_q       <= fe_d;
      ov_q       <= ov_d;
      ce_q       <= ce_d;
      cnt_q      <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= hold_q;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign bus.o_Shift_Enable = (state_q == S_LISTEN);
  assign bus.o_Busy         = (state_q == S_LISTEN) | (state_q == S_STOP);
  assign bus.o_Shift_Baud   = baud_q;
  assign bus.o_Rx_Data      = mem_q[rd_ptr_q];
  assign bus.o_Rx_Valid     = (cnt_q != '0);
  assign bus.o_Count        = cnt_q;
  assign bus.o_Frame_Err    = fe_q;
  assign bus.o_Overrun      = ov_q;
  assign bus.o_Cfg_Err      = ce_q;

endmodule

// File: tb/tb_rx_ctrl.sv
// Directed bench for rx_ctrl: a deadline/queue model checked every cycle,
// plus hand-computed literal checks for each scenario.
module tb_rx_ctrl;
  localparam int DEPTH = 4;
  localparam int AW = 2;
  localparam int IDLE_CYC = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rx_ctrl_if #(.AW(AW)) bus ();

  rx_ctrl #(.DEPTH(DEPTH), .AW(AW), .IDLE_CYC(IDLE_CYC)) dut (
    .i_Pclk(clk),
    .i_Rst (rst),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
               name, act, act, exp, exp, $time);
    end
  endtask

  // Model: session/listen flags, an absolute stop-sample deadline, and a byte queue.
  bit         m_session, m_listen;
  int         m_high_run;
  int         m_sample_at;
  int         m_cyc;
  logic [7:0] m_baud, m_held;
  logic [7:0] m_q[$];
  bit         m_fe, m_ov, m_ce;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_session = 0; m_listen = 0; m_high_run = 0; m_sample_at = -1;
      m_cyc = 0; m_baud = 0; m_held = 0; m_q.delete();
      m_fe = 0; m_ov = 0; m_ce = 0;
    end else begin
      bit pop_now, fe_s, ov_s, ce_s, push_now;
      int pre_size;
      pre_size = m_q.size();
      pop_now  = (pre_size > 0) && bus.i_Rx_Ready;
      fe_s = 0; ov_s = 0; ce_s = 0; push_now = 0;
      if (!bus.i_Rx_En) begin
        m_session = 0; m_listen = 0; m_sample_at = -1; m_high_run = 0;
      end else if (!m_session) begin
        if (bus.i_Baud >= 2) begin
          m_session = 1; m_baud = bus.i_Baud; m_high_run = 0;
          m_listen = 0; m_sample_at = -1;
        end else ce_s = 1;
      end else if (m_sample_at >= 0) begin
        if (m_cyc == m_sample_at) begin
          if (bus.i_Rx_Serial) push_now = 1; else fe_s = 1;
          m_sample_at = -1; m_high_run = 0;
        end
      end else if (m_listen) begin
        if (bus.i_Shift_Done) begin
          m_held = bus.i_Shift_Data;
          m_sample_at = m_cyc + 1 + int'(m_baud) / 2;
          m_listen = 0;
        end
      end else begin
        m_high_run = bus.i_Rx_Serial ? m_high_run + 1 : 0;
        if (m_high_run == IDLE_CYC) m_listen = 1;
      end
      if (pop_now) void'(m_q.pop_front());
      if (push_now) begin
        if (pre_size == DEPTH && !pop_now) ov_s = 1;
        else m_q.push_back(m_held);
      end
      m_fe = (m_fe && !bus.i_Clr_Err) || fe_s;
      m_ov = (m_ov && !bus.i_Clr_Err) || ov_s;
      m_ce = (m_ce && !bus.i_Clr_Err) || ce_s;
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("shift_en",   bus.o_Shift_Enable, m_listen);
      chk("busy",       bus.o_Busy, (m_listen || m_sample_at >= 0));
      chk("shift_baud", bus.o_Shift_Baud, m_baud);
      chk("count",      bus.o_Count, m_q.size());
      chk("valid",      bus.o_Rx_Valid, (m_q.size() > 0));
      if (m_q.size() > 0) chk("rx_data", bus.o_Rx_Data, m_q[0]);
      chk("frame_err",  bus.o_Frame_Err, m_fe);
      chk("overrun",    bus.o_Overrun, m_ov);
      chk("cfg_err",    bus.o_Cfg_Err, m_ce);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_arm();
    bit found;
    found = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.o_Shift_Enable) begin
        found = 1;
        break;
      end
      tick(1);
    end
    chk("arm_timeout", found, 1);
  endtask

  // Done pulse at cycle c; stop sample lands at c+1+baud/2 = c+44 for baud 87.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit,
                            input bit pop_at_sample, input int exp_before);
    wait_arm();
    bus.i_Rx_Serial = 1'b0;
    tick(3);
    bus.i_Shift_Done = 1'b1;
    bus.i_Shift_Data = d;
    tick(1);
    bus.i_Shift_Done = 1'b0;
    bus.i_Rx_Serial  = stop_bit;
    tick(43);
    if (pop_at_sample) bus.i_Rx_Ready = 1'b1;
    if (exp_before >= 0) chk("lat_before", bus.o_Count, exp_before);
    tick(1);
    bus.i_Rx_Ready = 1'b0;
    if (exp_before >= 0) chk("lat_after", bus.o_Count, exp_before + 1);
    bus.i_Rx_Serial = 1'b1;
  endtask

  task automatic clr_pulse();
    bus.i_Clr_Err = 1'b1;
    tick(1);
    bus.i_Clr_Err = 1'b0;
  endtask

  initial begin
    bus.i_Rx_En = 1'b0; bus.i_Baud = 8'd0; bus.i_Rx_Serial = 1'b1;
    bus.i_Shift_Data = 8'd0; bus.i_Shift_Done = 1'b0;
    bus.i_Rx_Ready = 1'b0; bus.i_Clr_Err = 1'b0;
    tick(3);
    chk("rst_count", bus.o_Count, 0);
    chk("rst_valid", bus.o_Rx_Valid, 0);
    chk("rst_data",  bus.o_Rx_Data, 0);
    chk("rst_baud",  bus.o_Shift_Baud, 0);
    chk("rst_sen",   bus.o_Shift_Enable, 0);
    rst = 1'b0;
    tick(1);

    // 1: arm timing
    bus.i_Rx_En = 1'b1; bus.i_Baud = 8'd87;
    tick(4);
    chk("t1_sen_c5", bus.o_Shift_Enable, 0);
    tick(1);
    chk("t1_sen_c6", bus.o_Shift_Enable, 1);
    chk("t1_baud",   bus.o_Shift_Baud, 87);

    // 2: good frame
    send_frame(8'hB5, 1'b1, 0, 0);
    chk("t2_valid", bus.o_Rx_Valid, 1);
    chk("t2_data",  bus.o_Rx_Data, 8'hB5);
    chk("t2_fe",    bus.o_Frame_Err, 0);
    chk("t2_ov",    bus.o_Overrun, 0);

    // 3: bad stop bit, then clear
    send_frame(8'h3C, 1'b0, 0, -1);
    chk("t3_fe",    bus.o_Frame_Err, 1);
    chk("t3_count", bus.o_Count, 1);
    clr_pulse();
    chk("t3_fe_clr", bus.o_Frame_Err, 0);
    chk("t3_head",   bus.o_Rx_Data, 8'hB5);
    bus.i_Rx_Ready = 1'b1; tick(1); bus.i_Rx_Ready = 1'b0;
    chk("t3_drain", bus.o_Count, 0);

    // 4a: overrun on fifth byte
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 0, -1);
    chk("t4_count", bus.o_Count, 4);
    chk("t4_ov",    bus.o_Overrun, 1);
    bus.i_Rx_Ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("t4_pop", bus.o_Rx_Data, i);
      tick(1);
    end
    bus.i_Rx_Ready = 1'b0;
    chk("t4_empty", bus.o_Rx_Valid, 0);
    clr_pulse();

    // 4b: pop coincides with the fifth push
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0, -1);
    send_frame(8'h05, 1'b1, 1, -1);
    chk("t4b_count", bus.o_Count, 4);
    chk("t4b_ov",    bus.o_Overrun, 0);
    bus.i_Rx_Ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("t4b_pop", bus.o_Rx_Data, i);
      tick(1);
    end
    bus.i_Rx_Ready = 1'b0;

    // 5: bad baud
    bus.i_Rx_En = 1'b0; tick(2);
    bus.i_Baud = 8'd1; bus.i_Rx_En = 1'b1; tick(3);
    chk("t5_ce",  bus.o_Cfg_Err, 1);
    chk("t5_sen", bus.o_Shift_Enable, 0);
    bus.i_Baud = 8'd87;
    wait_arm();
    chk("t5_ce_sticky", bus.o_Cfg_Err, 1);
    clr_pulse();
    chk("t5_ce_clr", bus.o_Cfg_Err, 0);

    // 6a: disable mid-LISTEN
    wait_arm();
    bus.i_Rx_Serial = 1'b0; tick(3);
    bus.i_Rx_En = 1'b0; tick(1);
    chk("t6a_sen",  bus.o_Shift_Enable, 0);
    bus.i_Shift_Done = 1'b1; bus.i_Shift_Data = 8'hAA; tick(1);
    bus.i_Shift_Done = 1'b0; tick(50);
    chk("t6a_count", bus.o_Count, 0);
    bus.i_Rx_Serial = 1'b1;

    // 6b: async reset mid-STOP
    bus.i_Rx_En = 1'b1; tick(1);
    send_frame(8'h11, 1'b1, 0, -1);
    send_frame(8'h22, 1'b0, 0, -1);
    wait_arm();
    bus.i_Rx_Serial = 1'b0; tick(3);
    bus.i_Shift_Done = 1'b1; bus.i_Shift_Data = 8'h33; tick(1);
    bus.i_Shift_Done = 1'b0; bus.i_Rx_Serial = 1'b1; tick(10);
    chk("t6b_busy",   bus.o_Busy, 1);
    chk("t6b_count0", bus.o_Count, 1);
    chk("t6b_fe0",    bus.o_Frame_Err, 1);
    rst = 1'b1;
    #1;
    chk("t6b_count", bus.o_Count, 0);
    chk("t6b_fe",    bus.o_Frame_Err, 0);
    chk("t6b_sen",   bus.o_Shift_Enable, 0);
    chk("t6b_busyr", bus.o_Busy, 0);
    chk("t6b_valid", bus.o_Rx_Valid, 0);
    tick(2);
    bus.i_Rx_En = 1'b0;
    rst = 1'b0;
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
